// File: rtl/priv_1_11_trap_sequencer.sv
// Trap-entry / MRET sequencer for the 1.11 privileged unit.
// Accepts one exception, interrupt or MRET event while idle, drains the
// pipeline (bounded by a timeout), emits exactly one CSR commit strobe, then
// redirects fetch to the trap vector or mepc and waits for fetch to accept it.
module priv_1_11_trap_sequencer #(
  parameter int VECTORED_EN    = 1,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        exception_req,
  input  logic [3:0]  exception_cause,
  input  logic [31:0] exception_epc,
  input  logic [31:0] exception_tval,
  input  logic        irq_pending,
  input  logic [3:0]  irq_cause,
  input  logic        mret_req,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] irq_epc,
  input  logic        pipe_clear,
  input  logic        pc_ack,
  output logic        flush_req,
  output logic        commit,
  output logic        commit_interrupt,
  output logic [3:0]  commit_cause,
  output logic [31:0] commit_epc,
  output logic [31:0] commit_tval,
  output logic        mret_commit,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        busy,
  output logic        timeout_err
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself; it saturates there.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_mret;
  logic              r_is_irq;
  logic [3:0]        r_cause;
  logic [31:0]       r_epc;
  logic [31:0]       r_tval;

  logic              w_take_exc;
  logic              w_take_irq;
  logic              w_take_mret;
  logic              w_any_req;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_drain_done;
  logic [31:0]       w_vec_base;
  logic [31:0]       w_vec_offset;
  logic              w_vectored;
  logic [31:0]       w_target;

  // Request arbitration (exception > irq > mret) and redirect target selection.
  always_comb begin
    w_take_exc   = exception_req;
    w_take_irq   = !exception_req && irq_pending;
    w_take_mret  = !exception_req && !irq_pending && mret_req;
    w_any_req    = exception_req || irq_pending || mret_req;
    w_cnt_inc    = r_cnt + 1'b1;
    w_drain_done = pipe_clear || (r_cnt == TMO);
    w_vec_base   = {mtvec[31:2], 2'b00};
    w_vec_offset = {26'd0, r_cause, 2'b00};
    w_vectored   = (VECTORED_EN != 0) && r_is_irq && (mtvec[1:0] == 2'b01);
    if (r_is_mret) begin
      w_target = mepc;
    end else if (w_vectored) begin
      w_target = w_vec_base + w_vec_offset;
    end else begin
      w_target = w_vec_base;
    end
  end

  // Sequencer state machine; every output is a register updated here.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_is_mret        <= 1'b0;
      r_is_irq         <= 1'b0;
      r_cause          <= 4'd0;
      r_epc            <= 32'd0;
      r_tval           <= 32'd0;
      flush_req        <= 1'b0;
      commit           <= 1'b0;
      commit_interrupt <= 1'b0;
      commit_cause     <= 4'd0;
      commit_epc       <= 32'd0;
      commit_tval      <= 32'd0;
      mret_commit      <= 1'b0;
      insert_pc        <= 1'b0;
      priv_pc          <= 32'd0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      commit      <= 1'b0;
      mret_commit <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_is_mret <= w_take_mret;
            r_is_irq  <= w_take_irq;
            if (w_take_exc) begin
              r_cause <= exception_cause;
              r_epc   <= exception_epc;
              r_tval  <= exception_tval;
            end else if (w_take_irq) begin
              r_cause <= irq_cause;
              r_epc   <= irq_epc;
              r_tval  <= 32'd0;
            end else begin
              r_cause <= 4'd0;
              r_epc   <= 32'd0;
              r_tval  <= 32'd0;
            end
            r_cnt       <= '0;
            r_state     <= S_DRAIN;
            flush_req   <= 1'b1;
            busy        <= 1'b1;
            // A zero timeout expires in the very first drain cycle.
            timeout_err <= (TMO == '0);
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_state   <= S_COMMIT;
            flush_req <= 1'b0;
            if (r_is_mret) begin
              mret_commit <= 1'b1;
            end else begin
              commit           <= 1'b1;
              commit_interrupt <= r_is_irq;
              commit_cause     <= r_cause;
              commit_epc       <= r_epc;
              commit_tval      <= r_tval;
            end
          end else begin
            r_cnt       <= w_cnt_inc;
            // Pulse in the drain cycle where the count reaches the limit.
            timeout_err <= (w_cnt_inc == TMO);
          end
        end
        S_COMMIT: begin
          r_state   <= S_REDIRECT;
          insert_pc <= 1'b1;
          priv_pc   <= w_target;
        end
        S_REDIRECT: begin
          if (pc_ack) begin
            r_state   <= S_IDLE;
            insert_pc <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          flush_req <= 1'b0;
          insert_pc <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
// Self-checking bench for priv_1_11_trap_sequencer: directed scenarios plus a
// randomized event loop, checked cycle by cycle against a timeline model.
module tb_priv_1_11_trap_sequencer;

  localparam int TMO    = 4;
  localparam int K_EXC  = 0;
  localparam int K_IRQ  = 1;
  localparam int K_MRET = 2;

  logic        CLK;
  logic        nRST;
  logic        exception_req;
  logic [3:0]  exception_cause;
  logic [31:0] exception_epc;
  logic [31:0] exception_tval;
  logic        irq_pending;
  logic [3:0]  irq_cause;
  logic        mret_req;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] irq_epc;
  logic        pipe_clear;
  logic        pc_ack;
  logic        flush_req;
  logic        commit;
  logic        commit_interrupt;
  logic [3:0]  commit_cause;
  logic [31:0] commit_epc;
  logic [31:0] commit_tval;
  logic        mret_commit;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        busy;
  logic        timeout_err;

  int n_checks;
  int n_errors;

  // Model of the last trap committed (commit_* hold these between strobes).
  logic        l_int;
  logic [3:0]  l_cause;
  logic [31:0] l_epc;
  logic [31:0] l_tval;

  priv_1_11_trap_sequencer #(
    .VECTORED_EN   (1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .exception_req   (exception_req),
    .exception_cause (exception_cause),
    .exception_epc   (exception_epc),
    .exception_tval  (exception_tval),
    .irq_pending     (irq_pending),
    .irq_cause       (irq_cause),
    .mret_req        (mret_req),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .irq_epc         (irq_epc),
    .pipe_clear      (pipe_clear),
    .pc_ack          (pc_ack),
    .flush_req       (flush_req),
    .commit          (commit),
    .commit_interrupt(commit_interrupt),
    .commit_cause    (commit_cause),
    .commit_epc      (commit_epc),
    .commit_tval     (commit_tval),
    .mret_commit     (mret_commit),
    .insert_pc       (insert_pc),
    .priv_pc         (priv_pc),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Redirect target from the architectural rules.
  function automatic logic [31:0] model_target(input int kind, input logic [3:0] cause,
                                               input logic [31:0] tv, input logic [31:0] ep);
    logic [31:0] base;
    base = tv - (tv % 4);
    if (kind == K_MRET) return ep;
    if (kind == K_IRQ && (tv % 4) == 1) return base + 32'(cause) * 4;
    return base;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flush"}, flush_req, 0);
    chk({tag, "_commit"}, commit, 0);
    chk({tag, "_cint"}, commit_interrupt, 0);
    chk({tag, "_ccause"}, commit_cause, 0);
    chk({tag, "_cepc"}, commit_epc, 0);
    chk({tag, "_ctval"}, commit_tval, 0);
    chk({tag, "_mret"}, mret_commit, 0);
    chk({tag, "_insert"}, insert_pc, 0);
    chk({tag, "_ppc"}, priv_pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_hint"}, commit_interrupt, l_int);
    chk({tag, "_hcause"}, commit_cause, l_cause);
    chk({tag, "_hepc"}, commit_epc, l_epc);
    chk({tag, "_htval"}, commit_tval, l_tval);
  endtask

  // Called #1 after a rising edge in an IDLE cycle with the request inputs
  // already driven. d = drain cycle index at which pipe_clear rises,
  // ackd = redirect cycle index at which pc_ack is given.
  task automatic run_event(input int kind, input logic [3:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval, input int d, input int ackd,
                           input bit hold_irq);
    logic [31:0] exp_pc;
    bit          leave;
    int          k;
    chk("idle_busy", busy, 0);
    chk("idle_insert", insert_pc, 0);
    exp_pc = model_target(kind, cause, mtvec, mepc);
    @(posedge CLK); #1;
    exception_req = 1'b0;
    mret_req      = 1'b0;
    exception_cause = 4'($urandom);
    exception_epc   = $urandom;
    exception_tval  = $urandom;
    if (!hold_irq) begin
      irq_pending = 1'b0;
      irq_cause   = 4'($urandom);
      irq_epc     = $urandom;
    end
    k = 0;
    forever begin
      chk("drain_flush", flush_req, 1);
      chk("drain_busy", busy, 1);
      chk("drain_tmo", timeout_err, (k == TMO));
      chk("drain_commit", commit | mret_commit, 0);
      chk("drain_insert", insert_pc, 0);
      pipe_clear = (k >= d);
      leave = (k >= d) || (k == TMO);
      @(posedge CLK); #1;
      if (leave) break;
      k++;
    end
    // Commit cycle
    chk("cm_commit", commit, (kind != K_MRET));
    chk("cm_mret", mret_commit, (kind == K_MRET));
    chk("cm_flush", flush_req, 0);
    chk("cm_tmo", timeout_err, 0);
    chk("cm_insert", insert_pc, 0);
    chk("cm_busy", busy, 1);
    if (kind != K_MRET) begin
      l_int   = (kind == K_IRQ);
      l_cause = cause;
      l_epc   = epc;
      l_tval  = (kind == K_IRQ) ? 32'd0 : tval;
    end
    chk_hold("cm");
    pipe_clear = 1'($urandom);
    @(posedge CLK); #1;
    for (int a = 0; a <= ackd; a++) begin
      chk("rd_insert", insert_pc, 1);
      chk("rd_pc", priv_pc, exp_pc);
      chk("rd_strobe", commit | mret_commit, 0);
      chk("rd_flush", flush_req, 0);
      chk("rd_busy", busy, 1);
      pc_ack        = (a == ackd);
      exception_req = 1'($urandom);
      mret_req      = 1'($urandom);
      @(posedge CLK); #1;
    end
    exception_req = 1'b0;
    mret_req      = 1'b0;
    pc_ack        = 1'b0;
    chk("post_insert", insert_pc, 0);
    chk("post_busy", busy, 0);
    chk("post_strobe", commit | mret_commit, 0);
    chk_hold("post");
  endtask

  task automatic drive_exc(input logic [3:0] c, input logic [31:0] e, input logic [31:0] t);
    exception_req   = 1'b1;
    exception_cause = c;
    exception_epc   = e;
    exception_tval  = t;
  endtask

  task automatic clear_model();
    l_int   = 1'b0;
    l_cause = 4'd0;
    l_epc   = 32'd0;
    l_tval  = 32'd0;
  endtask

  initial begin
    int kind;
    bit re, ri, rm;
    logic [3:0] c;
    n_checks = 0;
    n_errors = 0;
    clear_model();
    nRST = 1'b0;
    exception_req = 1'b0; exception_cause = 4'd0; exception_epc = 32'd0; exception_tval = 32'd0;
    irq_pending = 1'b0; irq_cause = 4'd0; mret_req = 1'b0;
    mtvec = 32'h0000_2001; mepc = 32'd0; irq_epc = 32'd0;
    pipe_clear = 1'b0; pc_ack = 1'b0;
    @(posedge CLK); #1;
    chk_reset_outs("rst");
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Exception, pipe_clear two cycles into drain, ack after a wait.
    drive_exc(4'd2, 32'h100, 32'hDEAD);
    mtvec = 32'h2001;
    run_event(K_EXC, 4'd2, 32'h100, 32'hDEAD, 2, 2, 1'b0);

    // Vectored interrupt, cause 7 -> 0x201C.
    irq_pending = 1'b1; irq_cause = 4'd7; irq_epc = 32'h300;
    run_event(K_IRQ, 4'd7, 32'h300, 32'd0, 0, 0, 1'b0);

    // All three requests together; the irq stays pending and follows.
    drive_exc(4'd5, 32'h500, 32'h55);
    irq_pending = 1'b1; irq_cause = 4'd3; irq_epc = 32'h600; mret_req = 1'b1;
    run_event(K_EXC, 4'd5, 32'h500, 32'h55, 1, 0, 1'b1);
    run_event(K_IRQ, 4'd3, 32'h600, 32'd0, 1, 0, 1'b0);

    // MRET.
    mepc = 32'h400; mret_req = 1'b1;
    run_event(K_MRET, 4'd0, 32'd0, 32'd0, 1, 1, 1'b0);

    // Drain timeout (pipe_clear never rises), then timeout coinciding with pipe_clear.
    drive_exc(4'd1, 32'h700, 32'h77);
    run_event(K_EXC, 4'd1, 32'h700, 32'h77, 1000, 0, 1'b0);
    drive_exc(4'd6, 32'h800, 32'h88);
    run_event(K_EXC, 4'd6, 32'h800, 32'h88, TMO, 0, 1'b0);

    // Reset during drain.
    drive_exc(4'd4, 32'h900, 32'h99);
    @(posedge CLK); #1;
    exception_req = 1'b0; pipe_clear = 1'b0;
    chk("rd1_flush", flush_req, 1);
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk_reset_outs("rst_drain");
    @(posedge CLK); #1;
    chk_reset_outs("rst_drain_hold");
    nRST = 1'b1;
    clear_model();
    @(posedge CLK); #1;

    // Reset during redirect.
    drive_exc(4'd9, 32'hA00, 32'hAA);
    @(posedge CLK); #1;
    exception_req = 1'b0; pipe_clear = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rr_insert", insert_pc, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_outs("rst_redir");
    @(posedge CLK); #1;
    chk_reset_outs("rst_redir_hold");
    nRST = 1'b1;
    pipe_clear = 1'b0;
    clear_model();
    @(posedge CLK); #1;

    // Normal operation after reset.
    drive_exc(4'd11, 32'hB00, 32'hBB);
    mtvec = 32'h3000;
    run_event(K_EXC, 4'd11, 32'hB00, 32'hBB, 0, 0, 1'b0);

    // Randomized events.
    for (int n = 0; n < 40; n++) begin
      re = 1'($urandom); ri = 1'($urandom); rm = 1'($urandom);
      if (!re && !ri && !rm) rm = 1'b1;
      mtvec = $urandom;
      mepc  = $urandom;
      exception_req = re; exception_cause = 4'($urandom);
      exception_epc = $urandom; exception_tval = $urandom;
      irq_pending = ri; irq_cause = 4'($urandom); irq_epc = $urandom;
      mret_req = rm;
      if (re) begin
        kind = K_EXC;
        c = exception_cause;
        run_event(kind, c, exception_epc, exception_tval,
                  $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
      end else if (ri) begin
        kind = K_IRQ;
        c = irq_cause;
        run_event(kind, c, irq_epc, 32'd0,
                  $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
      end else begin
        kind = K_MRET;
        run_event(kind, 4'd0, 32'd0, 32'd0,
                  $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priv_1_11_trap_sequencer.md
# priv_1_11_trap_sequencer

Sequencer for trap entry and MRET in the 1.11 privileged unit. It latches one exception, interrupt or MRET event, drains the pipeline, and issues exactly one single-cycle commit pulse for the CSR writes (mepc/mcause/mtval/mstatus). It then redirects fetch to the trap vector or to mepc with a PC handshake. It sits between the priv control logic (cause/pending detection) and pipeline control/fetch, and replaces ad-hoc latch registers with one explicit state machine.

## Interface
Parameters:
- VECTORED_EN, default 1: enables mtvec vectored mode (mode 01) for interrupts.
- TIMEOUT_CYCLES, default 63: maximum cycles spent in DRAIN before a forced commit.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- exception_req  in  1  exception detected this cycle
- exception_cause  in  4  exception code
- exception_epc  in  32  PC of faulting instruction
- exception_tval  in  32  trap value
- irq_pending  in  1  enabled, globally-unmasked interrupt pending
- irq_cause  in  4  interrupt code
- mret_req  in  1  MRET retiring
- mtvec  in  32  trap vector; [1:0] = mode
- mepc  in  32  current mepc CSR value
- irq_epc  in  32  PC to resume after an interrupt
- pipe_clear  in  1  pipeline fully drained
- pc_ack  in  1  fetch accepted priv_pc
- flush_req  out  1  request pipeline flush
- commit  out  1  one-cycle trap CSR write strobe
- commit_interrupt  out  1  mcause.interrupt value
- commit_cause  out  4  mcause code
- commit_epc  out  32  mepc write value
- commit_tval  out  32  mtval write value (0 for interrupts)
- mret_commit  out  1  one-cycle MRET mstatus-restore strobe
- insert_pc  out  1  redirect valid
- priv_pc  out  32  redirect target
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on drain timeout

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- In IDLE, sample requests with priority exception > irq > mret. On any request:
  - latch kind, cause, epc, tval (epc = irq_epc for interrupts);
  - clear the drain counter;
  - go to DRAIN.
- DRAIN: flush_req = 1; the counter increments each cycle.
  - pipe_clear = 1 -> COMMIT.
  - Counter reaching TIMEOUT_CYCLES -> pulse timeout_err, then COMMIT.
- COMMIT: exactly one cycle, then REDIRECT.
  - Trap: commit = 1, with the commit_* outputs driven from the latched event.
  - MRET: mret_commit = 1; commit = 0.
- Target computation at the COMMIT edge, registered into priv_pc:
  - MRET: priv_pc = mepc.
  - Interrupt with VECTORED_EN and mtvec[1:0] = 01: priv_pc = {mtvec[31:2],2'b00} + 4*cause, 32-bit wraparound.
  - Otherwise: priv_pc = {mtvec[31:2],2'b00}.
- REDIRECT: insert_pc = 1 and priv_pc stays stable until pc_ack. Sampling pc_ack = 1 -> IDLE.
- Requests arriving while busy are ignored; requesters hold or re-raise them. An irq that is still pending when the sequencer returns to IDLE is taken on that IDLE cycle.
- commit_* outputs hold their last values outside COMMIT. Only the strobes qualify them.

## Timing
- Reset: state IDLE. All strobes, flush_req, insert_pc, busy, timeout_err = 0; priv_pc, commit_epc, commit_tval, commit_cause, commit_interrupt = 0. Counter = 0.
- Request sampled at edge N -> DRAIN from N+1; flush_req and busy are high from N+1.
- If pipe_clear is already high in the first DRAIN cycle -> COMMIT at N+2 and REDIRECT at N+3. Minimum request-to-insert_pc latency is 3 cycles.
- pc_ack sampled in the first REDIRECT cycle -> IDLE next cycle. Minimum 4 cycles from request to ready for a new request.
- pipe_clear and timeout in the same cycle: timeout_err still pulses, and there is a single COMMIT.
- Exactly one commit or mret_commit per accepted event, never two.
- nRST asserted mid-operation: immediate return to IDLE with reset values. No partial commit is emitted.

## Test plan
- Exception: cause=2, epc=0x100, tval=0xDEAD, mtvec=0x2001; pipe_clear 2 cycles after entering DRAIN. Expect:
  - a single commit with interrupt=0, cause=2, epc=0x100, tval=0xDEAD;
  - priv_pc=0x2000 (exceptions are not vectored);
  - insert_pc held until pc_ack.
- Interrupt: irq cause=7, mtvec=0x2001, VECTORED_EN=1. Expect commit_interrupt=1, commit_tval=0, priv_pc=0x201C.
- Simultaneous exception_req, irq_pending and mret_req. Expect the exception to be taken; the still-pending irq is taken on the IDLE cycle after pc_ack.
- MRET with mepc=0x400. Expect mret_commit for one cycle, commit=0, priv_pc=0x400.
- pipe_clear never asserts with TIMEOUT_CYCLES=4. Expect timeout_err one cycle and the commit to follow; flush_req deasserts in COMMIT.
- nRST pulsed during DRAIN, then during REDIRECT. Expect all outputs at reset values and no strobes; a new request afterwards behaves normally.
